// File: rtl/seg7_scan_decoder.sv
// -----------------------------------------------------------------------------
// seg7_scan_decoder
//
// Receive side of the multiplexed 7-segment display link. The block samples
// the anode-select and segment lines of a scan driver and rebuilds the hex
// value shown on every digit. It serves as an on-chip loopback monitor and as
// the checker in driver benches.
//
// Line conventions: anodes are active-low one-hot. Segments are active-low in
// the bit order {a,b,c,d,e,f,g}, with segment a at bit 6.
//
// Optional feature: define SEG7_DECODER_DP_EN to add the decimal-point input
// dp_in and the per-digit output dp_out.
//
// Parameters
//   NUM_DIGITS     number of multiplexed digits (anode width)
//   SETTLE_CYCLES  consecutive stable synchronized cycles before a capture
//                  (1..255)
//
// Ports
//   clk               in   system clock, rising edge
//   reset             in   asynchronous active-low reset
//   anode_in          in   anode lines from the driver, active-low
//   seg_in            in   segment lines from the driver, active-low {a..g}
//   dp_in             in   decimal point, active-low (SEG7_DECODER_DP_EN only)
//   err_clr           in   synchronous clear of both sticky error flags
//   digit_out         out  decoded nibbles; digit k at [4k+3:4k]
//   digit_valid       out  bit k: last capture of digit k was a legal glyph
//   blank_mask        out  bit k: last capture of digit k was all-off
//   frame_done        out  one-cycle pulse once every digit has been captured
//   seg_error         out  sticky: an illegal glyph was captured
//   multi_anode_error out  sticky: several anodes were low and stable
//   dp_out            out  decimal point per digit (SEG7_DECODER_DP_EN only)
// -----------------------------------------------------------------------------
module seg7_scan_decoder #(
   parameter int NUM_DIGITS    = 4,
   parameter int SETTLE_CYCLES = 4
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [NUM_DIGITS-1:0]   anode_in,
   input  logic [6:0]              seg_in,
`ifdef SEG7_DECODER_DP_EN
   input  logic                    dp_in,
`endif
   input  logic                    err_clr,
   output logic [4*NUM_DIGITS-1:0] digit_out,
   output logic [NUM_DIGITS-1:0]   digit_valid,
   output logic [NUM_DIGITS-1:0]   blank_mask,
   output logic                    frame_done,
   output logic                    seg_error,
`ifdef SEG7_DECODER_DP_EN
   output logic                    multi_anode_error,
   output logic [NUM_DIGITS-1:0]   dp_out
`else
   output logic                    multi_anode_error
`endif
);

   localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [7:0] SETTLE_C = 8'(SETTLE_CYCLES);

   // The symbol is the group of lines that must stay stable before a capture.
   // The decimal point belongs to it when the feature is enabled.
`ifdef SEG7_DECODER_DP_EN
   localparam int SYM_W = 8;
`else
   localparam int SYM_W = 7;
`endif

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_HOLD   = 2'd2
   } state_e;

   // Glyph lookup. The result is {legal, blank, nibble}.
   function automatic logic [5:0] glyph_decode(input logic [6:0] seg);
      logic [5:0] res;
      case (seg)
         7'h01:   res = {2'b10, 4'h0};
         7'h4F:   res = {2'b10, 4'h1};
         7'h12:   res = {2'b10, 4'h2};
         7'h06:   res = {2'b10, 4'h3};
         7'h4C:   res = {2'b10, 4'h4};
         7'h24:   res = {2'b10, 4'h5};
         7'h20:   res = {2'b10, 4'h6};
         7'h0F:   res = {2'b10, 4'h7};
         7'h00:   res = {2'b10, 4'h8};
         7'h04:   res = {2'b10, 4'h9};
         7'h08:   res = {2'b10, 4'hA};
         7'h60:   res = {2'b10, 4'hB};
         7'h31:   res = {2'b10, 4'hC};
         7'h42:   res = {2'b10, 4'hD};
         7'h30:   res = {2'b10, 4'hE};
         7'h38:   res = {2'b10, 4'hF};
         7'h7F:   res = {2'b01, 4'h0};
         default: res = 6'b00_0000;
      endcase
      return res;
   endfunction

   // Returns the index of the low anode. Only meaningful when exactly one
   // anode is low.
   function automatic logic [IDX_W-1:0] low_index(input logic [NUM_DIGITS-1:0] an);
      logic [IDX_W-1:0] idx;
      idx = {IDX_W{1'b0}};
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         idx = an[i] ? idx : IDX_W'(i);
      end
      return idx;
   endfunction

   // Synchronizers and previous-cycle copies
   logic [NUM_DIGITS-1:0]   an_s1_q, an_s2_q, an_prev_q;
   logic [SYM_W-1:0]        sym_s1_q, sym_s2_q, sym_prev_q;
   logic [SYM_W-1:0]        sym_raw_s;

   // FSM
   state_e                  state_q, state_d;
   logic [7:0]              cnt_q, cnt_d;
   logic                    multi_rep_q, multi_rep_d;

   // Decoded conditions on the synchronized lines
   logic                    one_hot_s, multi_s, an_stable_s, sym_stable_s;
   logic [IDX_W-1:0]        low_idx_s;
   logic                    capture_s, multi_set_s;

   // Capture pipeline stage
   logic                    cap_vld_q;
   logic [IDX_W-1:0]        cap_idx_q;
   logic [SYM_W-1:0]        cap_sym_q;

   // Output registers
   logic [4*NUM_DIGITS-1:0] digit_q, digit_d;
   logic [NUM_DIGITS-1:0]   valid_q, valid_d;
   logic [NUM_DIGITS-1:0]   blank_q, blank_d;
   logic [NUM_DIGITS-1:0]   mask_q, mask_d;
   logic                    frame_q, frame_d;
   logic                    seg_err_q, seg_err_d;
   logic                    multi_err_q, multi_err_d;
   logic                    mask_full_s, seg_err_set_s;
   logic [5:0]              glyph_s;
`ifdef SEG7_DECODER_DP_EN
   logic [NUM_DIGITS-1:0]   dp_q, dp_d;

   assign sym_raw_s = {dp_in, seg_in};
`else
   assign sym_raw_s = seg_in;
`endif

   // Two-flop synchronizers, plus a copy of last cycle's synced values for the stability check
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         an_s1_q    <= {NUM_DIGITS{1'b1}};
         an_s2_q    <= {NUM_DIGITS{1'b1}};
         an_prev_q  <= {NUM_DIGITS{1'b1}};
         sym_s1_q   <= {SYM_W{1'b1}};
         sym_s2_q   <= {SYM_W{1'b1}};
         sym_prev_q <= {SYM_W{1'b1}};
      end else begin
         an_s1_q    <= anode_in;
         an_s2_q    <= an_s1_q;
         an_prev_q  <= an_s2_q;
         sym_s1_q   <= sym_raw_s;
         sym_s2_q   <= sym_s1_q;
         sym_prev_q <= sym_s2_q;
      end
   end

   // Classify the synchronized anode pattern and detect changes
   always_comb begin
      one_hot_s    = ($countones(~an_s2_q) == 32'd1);
      multi_s      = ($countones(~an_s2_q) > 32'd1);
      an_stable_s  = (an_s2_q == an_prev_q);
      sym_stable_s = (sym_s2_q == sym_prev_q);
      low_idx_s    = low_index(an_s2_q);
   end

   // FSM state register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= ST_IDLE;
         cnt_q       <= 8'd0;
         multi_rep_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         multi_rep_q <= multi_rep_d;
      end
   end

   // FSM next state. An anode change restarts the process from the new anode
   // pattern: SETTLE for one-hot, otherwise IDLE. The counter tracks how long a
   // multi-anode pattern has been stable while in IDLE.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      multi_rep_d = multi_rep_q;
      case (state_q)
         ST_IDLE: begin
            if (!an_stable_s || one_hot_s) begin
               multi_rep_d = 1'b0;
               if (one_hot_s) begin
                  state_d = ST_SETTLE;
                  cnt_d   = 8'd1;
               end else if (multi_s) begin
                  cnt_d = 8'd1;
               end else begin
                  cnt_d = 8'd0;
               end
            end else if (multi_s) begin
               // Hold at the threshold; the flag is raised only once per episode
               if (cnt_q == SETTLE_C) begin
                  multi_rep_d = 1'b1;
               end else begin
                  cnt_d = cnt_q + 8'd1;
               end
            end else begin
               cnt_d       = 8'd0;
               multi_rep_d = 1'b0;
            end
         end
         ST_SETTLE, ST_HOLD: begin
            if (!an_stable_s) begin
               multi_rep_d = 1'b0;
               if (one_hot_s) begin
                  state_d = ST_SETTLE;
                  cnt_d   = 8'd1;
               end else begin
                  state_d = ST_IDLE;
                  cnt_d   = multi_s ? 8'd1 : 8'd0;
               end
            end else if (!sym_stable_s) begin
               state_d = ST_SETTLE;
               cnt_d   = 8'd1;
            end else if (state_q == ST_SETTLE) begin
               if (cnt_q == SETTLE_C) begin
                  state_d = ST_HOLD;
               end else begin
                  cnt_d = cnt_q + 8'd1;
               end
            end else begin
               state_d = ST_HOLD;
            end
         end
         default: begin
            state_d     = ST_IDLE;
            cnt_d       = 8'd0;
            multi_rep_d = 1'b0;
         end
      endcase
   end

   // FSM outputs: capture request and multi-anode error request
   always_comb begin
      capture_s   = (state_q == ST_SETTLE) && an_stable_s && sym_stable_s &&
                    (cnt_q == SETTLE_C);
      multi_set_s = (state_q == ST_IDLE) && multi_s && an_stable_s &&
                    (cnt_q == SETTLE_C) && !multi_rep_q;
   end

   // Capture stage: latch the digit index and symbol to apply on the next edge
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cap_vld_q <= 1'b0;
         cap_idx_q <= {IDX_W{1'b0}};
         cap_sym_q <= {SYM_W{1'b0}};
      end else begin
         cap_vld_q <= capture_s;
         cap_idx_q <= low_idx_s;
         cap_sym_q <= sym_s2_q;
      end
   end

   // Output update: decode the captured symbol, maintain the frame mask and the sticky flags
   always_comb begin
      digit_d       = digit_q;
      valid_d       = valid_q;
      blank_d       = blank_q;
      mask_full_s   = &mask_q;
      // A completed mask empties on the pulse edge; a capture on that edge
      // immediately starts the next frame.
      mask_d        = mask_full_s ? {NUM_DIGITS{1'b0}} : mask_q;
      frame_d       = mask_full_s;
      seg_err_set_s = 1'b0;
      glyph_s       = glyph_decode(cap_sym_q[6:0]);
`ifdef SEG7_DECODER_DP_EN
      dp_d          = dp_q;
`endif
      if (cap_vld_q) begin
         mask_d[cap_idx_q] = 1'b1;
`ifdef SEG7_DECODER_DP_EN
         dp_d[cap_idx_q]   = ~cap_sym_q[7];
`endif
         if (glyph_s[5]) begin
            digit_d[{cap_idx_q, 2'b00} +: 4] = glyph_s[3:0];
            valid_d[cap_idx_q] = 1'b1;
            blank_d[cap_idx_q] = 1'b0;
         end else if (glyph_s[4]) begin
            valid_d[cap_idx_q] = 1'b0;
            blank_d[cap_idx_q] = 1'b1;
         end else begin
            valid_d[cap_idx_q] = 1'b0;
            blank_d[cap_idx_q] = 1'b0;
            seg_err_set_s      = 1'b1;
         end
      end else begin
         seg_err_set_s = 1'b0;
      end

      // A set in the same cycle as err_clr takes priority over the clear
      if (seg_err_set_s) begin
         seg_err_d = 1'b1;
      end else if (err_clr) begin
         seg_err_d = 1'b0;
      end else begin
         seg_err_d = seg_err_q;
      end

      if (multi_set_s) begin
         multi_err_d = 1'b1;
      end else if (err_clr) begin
         multi_err_d = 1'b0;
      end else begin
         multi_err_d = multi_err_q;
      end
   end

   // Output registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         digit_q     <= {(4*NUM_DIGITS){1'b0}};
         valid_q     <= {NUM_DIGITS{1'b0}};
         blank_q     <= {NUM_DIGITS{1'b0}};
         mask_q      <= {NUM_DIGITS{1'b0}};
         frame_q     <= 1'b0;
         seg_err_q   <= 1'b0;
         multi_err_q <= 1'b0;
`ifdef SEG7_DECODER_DP_EN
         dp_q        <= {NUM_DIGITS{1'b0}};
`endif
      end else begin
         digit_q     <= digit_d;
         valid_q     <= valid_d;
         blank_q     <= blank_d;
         mask_q      <= mask_d;
         frame_q     <= frame_d;
         seg_err_q   <= seg_err_d;
         multi_err_q <= multi_err_d;
`ifdef SEG7_DECODER_DP_EN
         dp_q        <= dp_d;
`endif
      end
   end

   assign digit_out         = digit_q;
   assign digit_valid       = valid_q;
   assign blank_mask        = blank_q;
   assign frame_done        = frame_q;
   assign seg_error         = seg_err_q;
   assign multi_anode_error = multi_err_q;
`ifdef SEG7_DECODER_DP_EN
   assign dp_out            = dp_q;
`endif

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// -----------------------------------------------------------------------------
// tb_seg7_scan_decoder
//
// Directed bench for seg7_scan_decoder using the default build
// (NUM_DIGITS = 4, SETTLE_CYCLES = 4). Inputs change 1 ns after a rising
// edge, and outputs are sampled 1 ns after a rising edge.
// -----------------------------------------------------------------------------
module tb_seg7_scan_decoder;

   logic        clk;
   logic        reset;
   logic [3:0]  anode_in;
   logic [6:0]  seg_in;
   logic        err_clr;
   logic [15:0] digit_out;
   logic [3:0]  digit_valid;
   logic [3:0]  blank_mask;
   logic        frame_done;
   logic        seg_error;
   logic        multi_anode_error;

   int checks = 0;
   int errors = 0;
   int frame_cnt = 0;
   int frame_base = 0;

   seg7_scan_decoder #(
      .NUM_DIGITS    (4),
      .SETTLE_CYCLES (4)
   ) dut (
      .clk               (clk),
      .reset             (reset),
      .anode_in          (anode_in),
      .seg_in            (seg_in),
      .err_clr           (err_clr),
      .digit_out         (digit_out),
      .digit_valid       (digit_valid),
      .blank_mask        (blank_mask),
      .frame_done        (frame_done),
      .seg_error         (seg_error),
      .multi_anode_error (multi_anode_error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Count frame_done pulses; each pulse spans exactly one falling edge
   always @(negedge clk) begin
      if (frame_done === 1'b1) frame_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance n rising edges and land 1 ns after the last one
   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic show(input logic [3:0] an, input logic [6:0] seg, input int n);
      anode_in = an;
      seg_in   = seg;
      cyc(n);
   endtask

   initial begin
      reset    = 1'b0;
      anode_in = 4'b1111;
      seg_in   = 7'h7F;
      err_clr  = 1'b0;

      // Reset state
      cyc(3);
      check("rst_digit", 32'(digit_out), 32'h0);
      check("rst_valid", 32'(digit_valid), 32'h0);
      check("rst_blank", 32'(blank_mask), 32'h0);
      check("rst_frame", 32'(frame_done), 32'h0);
      check("rst_segerr", 32'(seg_error), 32'h0);
      check("rst_multi", 32'(multi_anode_error), 32'h0);
      reset = 1'b1;
      cyc(3);

      // Single digit E on digit 0: 4 settle cycles + 3 latency
      anode_in = 4'b1110;
      seg_in   = 7'h30;
      cyc(7);
      check("lat_early_valid", 32'(digit_valid), 32'h0);
      cyc(1);
      check("lat_valid", 32'(digit_valid), 32'h1);
      check("lat_digit", 32'(digit_out), 32'h000E);
      check("lat_blank", 32'(blank_mask), 32'h0);

      // Full scan 1,4,5,D
      frame_base = frame_cnt;
      show(4'b1110, 7'h4F, 20);
      show(4'b1101, 7'h4C, 20);
      show(4'b1011, 7'h24, 20);
      show(4'b0111, 7'h42, 20);
      check("scan1_digit", 32'(digit_out), 32'hD541);
      check("scan1_valid", 32'(digit_valid), 32'hF);
      check("scan1_frames", 32'(frame_cnt - frame_base), 32'd1);

      // Identical second scan gives one more pulse
      frame_base = frame_cnt;
      show(4'b1110, 7'h4F, 20);
      show(4'b1101, 7'h4C, 20);
      show(4'b1011, 7'h24, 20);
      show(4'b0111, 7'h42, 20);
      check("scan2_digit", 32'(digit_out), 32'hD541);
      check("scan2_frames", 32'(frame_cnt - frame_base), 32'd1);

      // Illegal glyph on digit 2
      show(4'b1011, 7'h7E, 20);
      check("ill_segerr", 32'(seg_error), 32'h1);
      check("ill_valid", 32'(digit_valid), 32'hB);
      check("ill_digit", 32'(digit_out), 32'hD541);
      err_clr = 1'b1;
      cyc(1);
      err_clr = 1'b0;
      check("ill_clr", 32'(seg_error), 32'h0);

      // Two anodes low for 10 cycles
      show(4'b1100, 7'h7F, 10);
      check("multi_flag", 32'(multi_anode_error), 32'h1);
      check("multi_valid", 32'(digit_valid), 32'hB);
      err_clr = 1'b1;
      cyc(1);
      err_clr = 1'b0;
      check("multi_clr", 32'(multi_anode_error), 32'h0);
      show(4'b1111, 7'h7F, 5);

      // Anode held only 3 cycles: no capture
      show(4'b1101, 7'h12, 3);
      show(4'b1111, 7'h12, 12);
      check("short_digit", 32'(digit_out), 32'hD541);
      check("short_valid", 32'(digit_valid), 32'hB);
      check("short_multi", 32'(multi_anode_error), 32'h0);
      check("short_segerr", 32'(seg_error), 32'h0);

      // Blank on digit 1
      show(4'b1101, 7'h7F, 20);
      check("blank_mask", 32'(blank_mask), 32'h2);
      check("blank_valid", 32'(digit_valid), 32'h9);
      check("blank_digit", 32'(digit_out), 32'hD541);
      check("blank_segerr", 32'(seg_error), 32'h0);

      // Reset in the middle of SETTLE
      show(4'b1110, 7'h12, 4);
      #1;
      reset = 1'b0;
      #1;
      check("mid_rst_digit", 32'(digit_out), 32'h0);
      check("mid_rst_valid", 32'(digit_valid), 32'h0);
      check("mid_rst_blank", 32'(blank_mask), 32'h0);
      check("mid_rst_frame", 32'(frame_done), 32'h0);
      check("mid_rst_segerr", 32'(seg_error), 32'h0);
      check("mid_rst_multi", 32'(multi_anode_error), 32'h0);
      cyc(2);
      reset = 1'b1;
      cyc(7);
      check("post_rst_early", 32'(digit_valid), 32'h0);
      cyc(1);
      check("post_rst_valid", 32'(digit_valid), 32'h1);
      check("post_rst_digit", 32'(digit_out), 32'h0002);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
